cdma_axil_regs: RTL and testbench



---
 rtl/cdma_pkg.sv | 37 +++
 rtl/cdma_axil_rd_port.sv | 70 +++++++
 rtl/cdma_axil_regs.sv | 163 ++++++++++++++++
 tb/tb_cdma_axil_regs.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdma_pkg : register map, AXI response codes and engine state type    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cdma_pkg;

  localparam logic [31:0] REG_CR  = 32'h00;
  localparam logic [31:0] REG_SR  = 32'h04;
  localparam logic [31:0] REG_SA  = 32'h18;
  localparam logic [31:0] REG_DA  = 32'h20;
  localparam logic [31:0] REG_BTT = 32'h28;

  localparam int IOC_IRQ_BIT = 12;
  localparam int IDLE_BIT    = 1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } eng_state_e;

  // Shared read/write address check: misalignment outranks decode.
  function automatic logic [1:0] map_resp(input logic [31:0] addr);
    if (addr[1:0] != 2'b00) return SLVERR;
    case (addr)
      REG_CR, REG_SR, REG_SA, REG_DA, REG_BTT: return OKAY;
      default:                                 return DECERR;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdma_axil_rd_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdma_axil_rd_port : AXI4-Lite read handshake and register read mux   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cdma_axil_rd_port
  import cdma_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  input  logic [DATA_WIDTH-1:0] cr_i,
  input  logic [DATA_WIDTH-1:0] sr_i,
  input  logic [DATA_WIDTH-1:0] sa_i,
  input  logic [DATA_WIDTH-1:0] da_i,
  input  logic [DATA_WIDTH-1:0] btt_i
);

  logic [31:0]           addr;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  assign addr      = 32'(araddr_i);
  assign arready_o = arvalid_i & ~rvalid_q;

  always_comb begin
    rresp_d = map_resp(addr);
    rdata_d = '0;
    if (rresp_d == OKAY) begin
      case (addr)
        REG_CR:  rdata_d = cr_i;
        REG_SR:  rdata_d = sr_i;
        REG_SA:  rdata_d = sa_i;
        REG_DA:  rdata_d = da_i;
        REG_BTT: rdata_d = btt_i;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else if (arready_o) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;

endmodule
`default_nettype wire

// File: rtl/cdma_axil_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdma_axil_regs : copy-engine register file, launch FSM and interrupt |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cdma_axil_regs
  import cdma_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BTT_WIDTH  = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] src_addr,
  output logic [DATA_WIDTH-1:0] dst_addr,
  output logic [BTT_WIDTH-1:0]  btt,
  output logic                  xfer_start,
  input  logic                  xfer_done,
  output logic                  idle,
  output logic                  irq
);

  eng_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] sa_q, da_q;
  logic [BTT_WIDTH-1:0]  btt_q;
  logic                  ioc_en_q, ioc_q, ioc_d, irq_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic [31:0]           wr_addr;
  logic [BTT_WIDTH-1:0]  wr_btt;
  logic [1:0]            wr_resp;
  logic                  wr_accept, wr_ok, btt_launch, ioc_set, ioc_clr;
  logic [DATA_WIDTH-1:0] cr_val, sr_val;

  assign wr_addr   = 32'(awaddr);
  assign wr_btt    = wdata[BTT_WIDTH-1:0];
  assign wr_accept = awvalid & wvalid & ~bvalid_q;
  assign awready   = wr_accept;
  assign wready    = wr_accept;

  // Transfer parameters are frozen while the engine owns them.
  always_comb begin
    wr_resp = map_resp(wr_addr);
    if (wr_resp == OKAY) begin
      if ((wr_addr == REG_SA || wr_addr == REG_DA || wr_addr == REG_BTT) && state_q != IDLE)
        wr_resp = SLVERR;
      else if (wr_addr == REG_BTT && wr_btt == '0)
        wr_resp = SLVERR;
    end
  end

  assign wr_ok      = wr_accept && (wr_resp == OKAY);
  assign btt_launch = wr_ok && (wr_addr == REG_BTT);
  assign ioc_clr    = wr_ok && (wr_addr == REG_SR) && wdata[IOC_IRQ_BIT];
  assign ioc_set    = (state_q == BUSY) && xfer_done;
  assign ioc_d      = ioc_set | (ioc_q & ~ioc_clr);

  always_comb begin
    state_d    = state_q;
    xfer_start = 1'b0;
    idle       = 1'b0;
    case (state_q)
      IDLE: begin
        idle = 1'b1;
        if (btt_launch) state_d = START;
      end
      START: begin
        xfer_start = 1'b1;
        state_d    = BUSY;
      end
      BUSY:    if (xfer_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      da_q     <= '0;
      btt_q    <= '0;
      ioc_en_q <= 1'b0;
      ioc_q    <= 1'b0;
      irq_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      state_q <= state_d;
      ioc_q   <= ioc_d;
      irq_q   <= ioc_q & ioc_en_q;
      if (wr_ok) begin
        case (wr_addr)
          REG_CR:  ioc_en_q <= wdata[IOC_IRQ_BIT];
          REG_SA:  sa_q     <= wdata;
          REG_DA:  da_q     <= wdata;
          REG_BTT: btt_q    <= wr_btt;
          default: ;
        endcase
      end
      if (wr_accept) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    cr_val              = '0;
    cr_val[IOC_IRQ_BIT] = ioc_en_q;
    sr_val              = '0;
    sr_val[IOC_IRQ_BIT] = ioc_q;
    sr_val[IDLE_BIT]    = idle;
  end

  cdma_axil_rd_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .araddr_i  (araddr),
    .arvalid_i (arvalid),
    .arready_o (arready),
    .rdata_o   (rdata),
    .rresp_o   (rresp),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .cr_i      (cr_val),
    .sr_i      (sr_val),
    .sa_i      (sa_q),
    .da_i      (da_q),
    .btt_i     (DATA_WIDTH'(btt_q))
  );

  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign src_addr = sa_q;
  assign dst_addr = da_q;
  assign btt      = btt_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_cdma_axil_regs.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_cdma_axil_regs : directed-vector bench for cdma_axil_regs         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cdma_axil_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [9:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] src_addr, dst_addr;
  logic [25:0] btt;
  logic        xfer_start;
  logic        xfer_done = 1'b0;
  logic        idle, irq;

  int vectors = 0;
  int errors  = 0;
  int cyc = 0, start_cnt = 0, start_cyc = -1, acc_cyc = 0;

  cdma_axil_regs dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .src_addr(src_addr), .dst_addr(dst_addr), .btt(btt),
    .xfer_start(xfer_start), .xfer_done(xfer_done),
    .idle(idle), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (xfer_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [9:0] a, input logic [31:0] d,
                           output logic [1:0] resp, output bit same);
    int n = 0;
    same = 1'b1;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 20) begin
      if (awready !== wready) same = 1'b0;
      @(negedge clk);
      n++;
    end
    if (awready !== wready) same = 1'b0;
    if (awready !== 1'b1) begin
      vectors++; errors++;
      $display("FAIL aw_timeout addr=%h: awready=%b required 1", a, awready);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    resp = (bvalid === 1'b1) ? bresp : 2'bxx;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (arready !== 1'b1) begin
      vectors++; errors++;
      $display("FAIL ar_timeout addr=%h: arready=%b required 1", a, arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    d    = (rvalid === 1'b1) ? rdata : 32'hxxxx_xxxx;
    resp = (rvalid === 1'b1) ? rresp : 2'bxx;
    @(posedge clk); #1;
  endtask

  task automatic pulse_done();
    xfer_done = 1'b1;
    @(posedge clk); #1;
    xfer_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({awready, wready, bvalid, arready, rvalid, xfer_start, irq} !== 7'b0) begin
      errors++; $display("FAIL rst_ctrl: got %b required 0000000", {awready, wready, bvalid, arready, rvalid, xfer_start, irq});
    end
    vectors++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      errors++; $display("FAIL rst_resp: got bresp=%b rresp=%b rdata=%h required 0", bresp, rresp, rdata);
    end
    vectors++;
    if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b required 1", idle); end
    vectors++;
    if ({src_addr, dst_addr, btt} !== 90'h0) begin
      errors++; $display("FAIL rst_regs: got sa=%h da=%h btt=%h required 0", src_addr, dst_addr, btt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_program();
    logic [1:0] r; bit s; int s0;
    s0 = start_cnt;
    axi_write(10'h18, 32'h0002_0000, r, s);
    vectors++;
    if (r !== 2'b00 || !s) begin errors++; $display("FAIL prog_sa: resp=%b same=%0d required 00/1", r, s); end
    axi_write(10'h20, 32'h0000_0000, r, s);
    vectors++;
    if (r !== 2'b00 || !s) begin errors++; $display("FAIL prog_da: resp=%b same=%0d required 00/1", r, s); end
    axi_write(10'h28, 32'd20, r, s);
    vectors++;
    if (r !== 2'b00 || !s) begin errors++; $display("FAIL prog_btt: resp=%b same=%0d required 00/1", r, s); end
    vectors++;
    if (start_cnt !== s0 + 1 || start_cyc !== acc_cyc + 1) begin
      errors++; $display("FAIL prog_start: pulses=%0d at cyc %0d required 1 at cyc %0d", start_cnt - s0, start_cyc, acc_cyc + 1);
    end
    vectors++;
    if (idle !== 1'b0 || btt !== 26'd20 || src_addr !== 32'h0002_0000) begin
      errors++; $display("FAIL prog_outs: idle=%b btt=%h sa=%h required 0/14/00020000", idle, btt, src_addr);
    end
  endtask

  task automatic test_busy();
    logic [1:0] r; bit s; logic [31:0] d;
    axi_write(10'h18, 32'h0000_1234, r, s);
    vectors++;
    if (r !== 2'b10) begin errors++; $display("FAIL busy_sa_wr: resp=%b required 10", r); end
    axi_read(10'h18, d, r);
    vectors++;
    if (d !== 32'h0002_0000 || r !== 2'b00) begin errors++; $display("FAIL busy_sa_rd: got %h/%b required 00020000/00", d, r); end
    axi_read(10'h04, d, r);
    vectors++;
    if (d !== 32'h0000_0000) begin errors++; $display("FAIL busy_sr: got %h required 00000000", d); end
    pulse_done();
    vectors++;
    if (idle !== 1'b1) begin errors++; $display("FAIL done_idle: got %b required 1", idle); end
    axi_read(10'h04, d, r);
    vectors++;
    if (d !== 32'h0000_1002 || r !== 2'b00) begin errors++; $display("FAIL done_sr: got %h/%b required 00001002/00", d, r); end
    vectors++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b required 0", irq); end
  endtask

  task automatic test_irq();
    logic [1:0] r; bit s; logic [31:0] d;
    axi_write(10'h00, 32'h0000_1000, r, s);
    vectors++;
    if (r !== 2'b00 || irq !== 1'b1) begin errors++; $display("FAIL irq_en: resp=%b irq=%b required 00/1", r, irq); end
    axi_read(10'h00, d, r);
    vectors++;
    if (d !== 32'h0000_1000) begin errors++; $display("FAIL cr_rd: got %h required 00001000", d); end
    axi_write(10'h28, 32'd8, r, s);
    vectors++;
    if (r !== 2'b00 || idle !== 1'b0) begin errors++; $display("FAIL irq_launch: resp=%b idle=%b required 00/0", r, idle); end
    awaddr = 10'h04; wdata = 32'h0000_1000; awvalid = 1'b1; wvalid = 1'b1; xfer_done = 1'b1;
    @(negedge clk);
    vectors++;
    if (awready !== 1'b1) begin errors++; $display("FAIL w1c_race_acc: awready=%b required 1", awready); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; xfer_done = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (irq !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL w1c_race: irq=%b idle=%b required 1/1", irq, idle); end
    axi_read(10'h04, d, r);
    vectors++;
    if (d !== 32'h0000_1002) begin errors++; $display("FAIL w1c_race_sr: got %h required 00001002", d); end
    axi_write(10'h04, 32'h0000_1000, r, s);
    vectors++;
    if (r !== 2'b00 || irq !== 1'b0) begin errors++; $display("FAIL w1c_clear: resp=%b irq=%b required 00/0", r, irq); end
    axi_read(10'h04, d, r);
    vectors++;
    if (d !== 32'h0000_0002) begin errors++; $display("FAIL w1c_sr: got %h required 00000002", d); end
  endtask

  task automatic test_errors();
    logic [1:0] r; bit s; logic [31:0] d; int s0;
    s0 = start_cnt;
    axi_write(10'h28, 32'h0000_0000, r, s);
    vectors++;
    if (r !== 2'b10) begin errors++; $display("FAIL btt_zero: resp=%b required 10", r); end
    axi_write(10'h28, 32'h0400_0000, r, s);
    vectors++;
    if (r !== 2'b10) begin errors++; $display("FAIL btt_trunc_zero: resp=%b required 10", r); end
    axi_write(10'h3C, 32'h1111_1111, r, s);
    vectors++;
    if (r !== 2'b11) begin errors++; $display("FAIL wr_unmapped: resp=%b required 11", r); end
    axi_write(10'h19, 32'h2222_2222, r, s);
    vectors++;
    if (r !== 2'b10) begin errors++; $display("FAIL wr_misalign: resp=%b required 10", r); end
    vectors++;
    if (start_cnt !== s0 || idle !== 1'b1) begin errors++; $display("FAIL err_nolaunch: pulses=%0d idle=%b required 0/1", start_cnt - s0, idle); end
    axi_read(10'h28, d, r);
    vectors++;
    if (d !== 32'd8) begin errors++; $display("FAIL btt_kept: got %h required 00000008", d); end
    axi_read(10'h3C, d, r);
    vectors++;
    if (d !== 32'h0 || r !== 2'b11) begin errors++; $display("FAIL rd_unmapped: got %h/%b required 0/11", d, r); end
    axi_read(10'h1A, d, r);
    vectors++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL rd_misalign: got %h/%b required 0/10", d, r); end
    axi_write(10'h28, 32'hFFFF_FFFF, r, s);
    axi_read(10'h28, d, r);
    vectors++;
    if (d !== 32'h03FF_FFFF || start_cnt !== s0 + 1) begin
      errors++; $display("FAIL btt_upper: got %h pulses=%0d required 03ffffff/1", d, start_cnt - s0);
    end
    pulse_done();
    vectors++;
    if (idle !== 1'b1) begin errors++; $display("FAIL btt_upper_done: idle=%b required 1", idle); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; logic [31:0] d;
    bready = 1'b0;
    awaddr = 10'h20; wdata = 32'hAAAA_0000; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    vectors++;
    if (awready !== 1'b1 || wready !== 1'b1) begin errors++; $display("FAIL bp_first_acc: aw=%b w=%b required 1/1", awready, wready); end
    @(posedge clk); #1;
    awaddr = 10'h18; wdata = 32'h0000_5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: bvalid=%b bresp=%b aw=%b w=%b required 1/00/0/0", i, bvalid, bresp, awready, wready);
      end
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b1 || awready !== 1'b0) begin errors++; $display("FAIL bp_release: bvalid=%b aw=%b required 1/0", bvalid, awready); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin errors++; $display("FAIL bp_second_acc: aw=%b bvalid=%b required 1/0", awready, bvalid); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL bp_second_b: bvalid=%b bresp=%b required 1/00", bvalid, bresp); end
    @(posedge clk); #1;
    axi_read(10'h20, d, r);
    vectors++;
    if (d !== 32'hAAAA_0000) begin errors++; $display("FAIL bp_da: got %h required aaaa0000", d); end
    axi_read(10'h18, d, r);
    vectors++;
    if (d !== 32'h0000_5555) begin errors++; $display("FAIL bp_sa: got %h required 00005555", d); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; bit s; logic [31:0] d; int s0;
    axi_write(10'h28, 32'd4, r, s);
    vectors++;
    if (r !== 2'b00 || idle !== 1'b0) begin errors++; $display("FAIL mid_launch: resp=%b idle=%b required 00/0", r, idle); end
    s0 = start_cnt;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (idle !== 1'b1 || irq !== 1'b0 || src_addr !== 32'h0 || dst_addr !== 32'h0 || btt !== 26'h0) begin
      errors++; $display("FAIL mid_rst: idle=%b irq=%b sa=%h da=%h btt=%h required 1/0/0/0/0", idle, irq, src_addr, dst_addr, btt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_done();
    @(posedge clk); #1;
    vectors++;
    if (idle !== 1'b1 || irq !== 1'b0 || start_cnt !== s0) begin
      errors++; $display("FAIL mid_done_ignored: idle=%b irq=%b pulses=%0d required 1/0/0", idle, irq, start_cnt - s0);
    end
    axi_read(10'h04, d, r);
    vectors++;
    if (d !== 32'h0000_0002) begin errors++; $display("FAIL mid_sr: got %h required 00000002", d); end
    axi_read(10'h00, d, r);
    vectors++;
    if (d !== 32'h0000_0000) begin errors++; $display("FAIL mid_cr: got %h required 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_busy();
    test_irq();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
